// File: rtl/rst_seq_pkg.sv
// Shared state encoding and helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    HOLD      = 3'd5
  } state_e;

  // Core reset is held in every state before the stable count completes, and in HOLD.
  function automatic logic core_held(input state_e s);
    return (s == RESET) || (s == WAIT_LOCK) || (s == STABLE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset, reused for async inputs.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases core then peripheral reset after PLL lock is stable.
// Optional lock-loss glitch filter enabled by defining RST_SEQ_LOCK_FILTER_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned SOFT_HOLD     = 32,
  parameter int unsigned LOCK_FILTER   = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic soft_rst_i,
  output logic rst_core_o,
  output logic rst_periph_o,
  output logic ready_o,
  output logic lock_lost_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lost_q, lost_d;
  logic             core_q, periph_q, ready_q;
  logic             lock_s;
  logic             lock_loss;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (lock_i),
    .q_o   (lock_s)
  );

`ifdef RST_SEQ_LOCK_FILTER_EN
  logic [CNT_W-1:0] filt_q, filt_d;

  // Saturates at LOCK_FILTER so a long outage cannot wrap back into "short drop".
  always_comb begin
    filt_d = filt_q;
    if (lock_s)
      filt_d = '0;
    else if (filt_q != CNT_W'(LOCK_FILTER))
      filt_d = filt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) filt_q <= '0;
    else       filt_q <= filt_d;
  end

  assign lock_loss = !lock_s && (filt_q >= CNT_W'(LOCK_FILTER - 1));
`else
  assign lock_loss = !lock_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      RESET: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (lock_loss) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE, RUN, HOLD: begin
        if (lock_loss) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end else if (soft_rst_i && state_q != HOLD) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (state_q == RELEASE && cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (state_q == HOLD && cnt_q == CNT_W'(SOFT_HOLD - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (state_q != RUN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they are registered and change together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RESET;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      core_q   <= 1'b1;
      periph_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      core_q   <= core_held(state_d);
      periph_q <= (state_d != RUN);
      ready_q  <= (state_d == RUN);
    end
  end

  assign rst_core_o   = core_q;
  assign rst_periph_o = periph_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a timeline model predicts outputs per edge, a monitor compares.
module tb_rst_seq;

  localparam int S  = 8;
  localparam int G  = 4;
  localparam int H  = 6;
  localparam int LF = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1, lock_i = 1'b0, soft_rst_i = 1'b0;
  logic rst_core_o, rst_periph_o, ready_o, lock_lost_o;

  always #5 clk = ~clk;

  rst_seq #(
    .STABLE_CYCLES (S),
    .STAGE_GAP     (G),
    .SOFT_HOLD     (H),
    .LOCK_FILTER   (LF),
    .CNT_W         (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .lock_i       (lock_i),
    .soft_rst_i   (soft_rst_i),
    .rst_core_o   (rst_core_o),
    .rst_periph_o (rst_periph_o),
    .ready_o      (ready_o),
    .lock_lost_o  (lock_lost_o)
  );

  typedef struct packed {
    logic core;
    logic periph;
    logic ready;
    logic lost;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: lock seen two samples late; m_age = edges since the stable count began.
  // Core is released once m_age reaches S, peripherals at S+G; a soft reset rewinds
  // m_age to S-H so the hold ends exactly where the stable count would have.
  bit m_start, m_wait, m_hold, m_lost, h1, h2;
  int m_age, m_low;

  task automatic model_step(input bit r, input bit l, input bit s);
    bit   ls, loss;
    exp_t e;
    if (r) begin
      m_start = 0; m_wait = 0; m_hold = 0; m_lost = 0;
      h1 = 0; h2 = 0; m_age = 0; m_low = 0;
    end else begin
      ls = h2; h2 = h1; h1 = l;
      m_low = ls ? 0 : ((m_low < 1000) ? m_low + 1 : m_low);
`ifdef RST_SEQ_LOCK_FILTER_EN
      loss = (m_low >= LF);
`else
      loss = !ls;
`endif
      if (!m_start) begin
        m_start = 1; m_wait = 1;
      end else if (m_wait) begin
        if (ls) begin m_wait = 0; m_age = 0; m_hold = 0; end
      end else if (loss) begin
        if (m_age >= S || m_hold) m_lost = 1;
        m_wait = 1;
      end else if (s && m_age >= S) begin
        m_age = S - H; m_hold = 1;
      end else begin
        if (m_age < S + G) m_age++;
        if (m_age >= S) m_hold = 0;
      end
    end
    e.core   = !m_start || m_wait || (m_age < S);
    e.periph = !(m_start && !m_wait && m_age >= S + G);
    e.ready  = !e.periph;
    e.lost   = m_lost;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit l, input bit s);
    @(negedge clk);
    rst_i = r; lock_i = l; soft_rst_i = s;
    @(posedge clk);
    model_step(r, l, s);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rst_core",   rst_core_o,   e.core);
        check("rst_periph", rst_periph_o, e.periph);
        check("ready",      ready_o,      e.ready);
        check("lock_lost",  lock_lost_o,  e.lost);
      end
    end
  end

  initial begin
    bit lk, found;
    int drop;
    // Power-up with lock held high
    repeat (3) cycle(1, 1, 0);
    repeat (20) cycle(0, 1, 0);
    // Soft reset in RUN
    cycle(0, 1, 1);
    repeat (15) cycle(0, 1, 0);
    // Single-cycle lock drop in RUN
    cycle(0, 0, 0);
    repeat (5) cycle(0, 1, 0);
    // Reset mid-RELEASE while lock_lost is set
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_start && !m_wait && m_age >= S && m_age < S + G) found = 1;
      else cycle(0, 1, 0);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_release: got timeout expected RELEASE within 40 cycles");
    end
    cycle(1, 1, 0);
    // Lock low for 50 cycles after reset, then rises
    repeat (50) cycle(0, 0, 0);
    repeat (20) cycle(0, 1, 0);
    // Soft request on the same edge the synchronised lock falls
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    repeat (20) cycle(0, 1, 0);
    // Four-cycle drop
    repeat (4) cycle(0, 0, 0);
    repeat (20) cycle(0, 1, 0);
    // Randomised traffic
    lk = 1; drop = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop > 0) begin
        drop--; lk = 0;
      end else begin
        lk = 1;
        if ($urandom_range(0, 59) == 0) drop = $urandom_range(1, 6);
      end
      cycle(($urandom_range(0, 399) == 0), lk, ($urandom_range(0, 24) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
